datapath_mem_seq: RTL and testbench
===================================

Name: datapath_mem_seq

Overview:
- Parametrised successor of the single-bus Mini-SRC datapath: one shared bus with one-hot source select, register file, PC/IR/Y/Z/HI/LO/MDR/MAR and in/out ports.
- Adds a registered MAR, a defined bus value on bad selects, and a sticky conflict flag.
- Adds a req/ack memory sequencer with timeout, so MDR loads/stores are real multi-cycle transactions rather than emulated data.
- The ALU stays external; this block exports its operands and captures its 2*WIDTH result into Z.

Parameters:
WIDTH, 32, datapath/bus width
NREGS, 16, general register count (power of 2, >=2)
PC_STEP, 1, PC increment amount
CONST_BITS, 19, IR immediate field width; bus gets IR[CONST_BITS-1:0] sign-extended from bit CONST_BITS-1
MEM_TIMEOUT, 15, max wait cycles for in_mem_ack (>=1)

Ports:
clk  in  1  clock, rising edge
in_clr  in  1  reset: asynchronous, active-high; clears all state
in_bus_sel  in  9  one-hot bus source: b0 regfile, b1 HI, b2 LO, b3 Z[2W-1:W], b4 Z[W-1:0], b5 PC, b6 MDR, b7 InPort, b8 C sign-extend
in_write_en  in  10  load enables: b0 regfile, b1 HI, b2 LO, b3 Z, b4 PC, b5 MDR, b6 IR, b7 Y, b8 MAR, b9 OutPort
in_reg_addr  in  log2(NREGS)  regfile read/write index
in_baout  in  1  when 1 and in_reg_addr==0, regfile read returns 0
in_inc_pc  in  1  PC <= PC + PC_STEP
in_mem_read  in  1  start memory read (MDR <= memory[MAR])
in_mem_write  in  1  start memory write (memory[MAR] <= MDR)
in_mem_ack  in  1  memory completion
in_mem_rdata  in  WIDTH  memory read data
in_inport_data  in  WIDTH  external input port
in_alu_result  in  2*WIDTH  external ALU result
out_alu_a  out  WIDTH  Y register
out_alu_b  out  WIDTH  current bus
out_mem_addr  out  WIDTH  MAR
out_mem_wdata  out  WIDTH  MDR
out_mem_rd  out  1  read strobe
out_mem_wr  out  1  write strobe
out_mem_done  out  1  one-cycle completion pulse
out_mem_timeout  out  1  sticky timeout flag
out_busy  out  1  sequencer not IDLE
out_bus  out  WIDTH  bus value
out_bus_err  out  1  sticky multi-select flag
out_ir  out  WIDTH  IR
out_outport  out  WIDTH  OutPort register

Behaviour:
- Reset: every register, regfile entry, flag and strobe is 0; the sequencer goes to IDLE. This takes effect immediately, including mid-transaction.
- Bus is combinational:
  - Exactly one in_bus_sel bit set: the bus carries that source.
  - All select bits zero: bus = 0.
  - More than one bit set: bus = 0, and out_bus_err is set on the next edge and stays set until reset.
- Load enables:
  - All loads happen at the rising edge from the bus, except Z, which loads in_alu_result.
  - Several enables may be active in the same cycle.
- PC:
  - If in_inc_pc is 1, PC <= PC + PC_STEP, modulo 2^WIDTH.
  - Else if write_en b4 is 1, PC <= bus.
  - in_inc_pc has priority over write_en b4.
- InPort samples in_inport_data every cycle; 1-cycle latency to the bus.
- Regfile read:
  - Combinational at in_reg_addr.
  - Returns 0 if in_baout is 1 and the index is 0.
  - A write to R0 still stores the value.
- Sequencer states: IDLE, RD, WR, DONE.
  - IDLE -> RD on in_mem_read.
  - IDLE -> WR on in_mem_write.
  - If both requests are high, the read wins and the write is dropped.
  - RD: out_mem_rd=1. On in_mem_ack, MDR <= in_mem_rdata and go to DONE.
  - WR: out_mem_wr=1. On in_mem_ack, go to DONE.
  - DONE: out_mem_done=1 for one cycle, then IDLE.
- Strobe timing:
  - out_mem_rd and out_mem_wr assert in the first cycle after the request edge.
  - Minimum latency, request to done pulse, is 2 cycles.
- Stability while busy:
  - MAR and MDR bus loads are ignored while the state is RD or WR, so address and data stay stable.
  - New in_mem_read/in_mem_write requests are ignored while out_busy is 1.
- Timeout:
  - A wait counter clears on entry to RD/WR.
  - If it reaches MEM_TIMEOUT with no ack: set out_mem_timeout (sticky), leave MDR unchanged, go to DONE.
  - If ack arrives in the same cycle the counter reaches MEM_TIMEOUT, the ack wins and no timeout is flagged.
- out_busy = (state != IDLE).
- An ack in IDLE or DONE is ignored.

Test Plan:
- Reset clears state: assert in_clr mid-RD -> out_mem_rd=0 immediately; PC=0, out_busy=0, all flags 0.
- Bus select and conflict: regfile R3=0x1234 loaded via in_inport_data path, then sel=b0, addr=3 -> out_bus=0x1234. sel=0x003 -> out_bus=0 and out_bus_err=1 next cycle, held until reset.
- PC increment priority: PC=0xFFFFFFFF, PC_STEP=1, in_inc_pc=1 with write_en b4=1 and bus=5 -> PC=0x00000000.
- Memory read: MAR=0x40, pulse in_mem_read, ack 3 cycles after the strobe with rdata 0xDEADBEEF -> MDR=0xDEADBEEF; done pulses 1 cycle; a MAR write during the wait is ignored (out_mem_addr stays 0x40).
- Write timeout: MDR=0xA5, pulse in_mem_write, never ack -> out_mem_wr held 15 cycles, then done pulse and out_mem_timeout=1; a subsequent acked read still completes normally.
- C sign-extend, BAout and Z capture: IR=0x00040000, sel=b8 -> bus=0xFFFC0000. in_baout=1, addr=0 -> bus=0. Z load with in_alu_result=0x1_00000002 -> Z hi/lo selects read 0x1 / 0x2.

Source files
------------

// File: rtl/datapath_mem_seq.sv
// Single-bus datapath: register file, special registers and ports share one bus,
// with a req/ack memory sequencer that moves data between MDR and external memory.
module datapath_mem_seq #(
  parameter int WIDTH       = 32,
  parameter int NREGS       = 16,
  parameter int PC_STEP     = 1,
  parameter int CONST_BITS  = 19,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                     clk,
  input  logic                     in_clr,
  input  logic [8:0]               in_bus_sel,
  input  logic [9:0]               in_write_en,
  input  logic [$clog2(NREGS)-1:0] in_reg_addr,
  input  logic                     in_baout,
  input  logic                     in_inc_pc,
  input  logic                     in_mem_read,
  input  logic                     in_mem_write,
  input  logic                     in_mem_ack,
  input  logic [WIDTH-1:0]         in_mem_rdata,
  input  logic [WIDTH-1:0]         in_inport_data,
  input  logic [2*WIDTH-1:0]       in_alu_result,
  output logic [WIDTH-1:0]         out_alu_a,
  output logic [WIDTH-1:0]         out_alu_b,
  output logic [WIDTH-1:0]         out_mem_addr,
  output logic [WIDTH-1:0]         out_mem_wdata,
  output logic                     out_mem_rd,
  output logic                     out_mem_wr,
  output logic                     out_mem_done,
  output logic                     out_mem_timeout,
  output logic                     out_busy,
  output logic [WIDTH-1:0]         out_bus,
  output logic                     out_bus_err,
  output logic [WIDTH-1:0]         out_ir,
  output logic [WIDTH-1:0]         out_outport
);

  localparam int AW = $clog2(NREGS);
  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_t;

  state_t r_state;
  state_t w_state_next;

  logic [WIDTH-1:0]   r_regs [NREGS];
  logic [WIDTH-1:0]   r_hi, r_lo, r_pc, r_mdr, r_ir, r_y, r_mar, r_outport, r_inport;
  logic [2*WIDTH-1:0] r_z;
  logic               r_bus_err, r_timeout;
  logic [CW-1:0]      r_wait;

  logic [WIDTH-1:0]   w_src   [9];
  logic [WIDTH-1:0]   w_gated [9];
  logic [WIDTH-1:0]   w_bus_or;
  logic [WIDTH-1:0]   w_bus;
  logic [WIDTH-1:0]   w_reg_rd;
  logic [WIDTH-1:0]   w_cext;
  logic               w_multi;
  logic               w_mem_active;
  logic               w_rd_capture;
  logic               w_timeout_hit;

  assign w_reg_rd = (in_baout && (in_reg_addr == '0)) ? '0 : r_regs[in_reg_addr];
  assign w_cext   = {{(WIDTH-CONST_BITS){r_ir[CONST_BITS-1]}}, r_ir[CONST_BITS-1:0]};

  assign w_src[0] = w_reg_rd;
  assign w_src[1] = r_hi;
  assign w_src[2] = r_lo;
  assign w_src[3] = r_z[2*WIDTH-1:WIDTH];
  assign w_src[4] = r_z[WIDTH-1:0];
  assign w_src[5] = r_pc;
  assign w_src[6] = r_mdr;
  assign w_src[7] = r_inport;
  assign w_src[8] = w_cext;

  generate
    for (genvar gi = 0; gi < 9; gi++) begin : g_bus_src
      assign w_gated[gi] = in_bus_sel[gi] ? w_src[gi] : '0;
    end
  endgenerate

  // x & (x-1) is nonzero exactly when more than one select bit is set
  assign w_multi = |(in_bus_sel & (in_bus_sel - 9'd1));

  always_comb begin
    w_bus_or = '0;
    for (int i = 0; i < 9; i++) begin
      w_bus_or = w_bus_or | w_gated[i];
    end
  end

  assign w_bus        = w_multi ? '0 : w_bus_or;
  assign w_mem_active = (r_state == S_RD) || (r_state == S_WR);

  always_comb begin
    w_state_next  = r_state;
    w_rd_capture  = 1'b0;
    w_timeout_hit = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (in_mem_read)       w_state_next = S_RD;
        else if (in_mem_write) w_state_next = S_WR;
      end
      S_RD, S_WR: begin
        if (in_mem_ack) begin
          w_rd_capture = (r_state == S_RD);
          w_state_next = S_DONE;
        end else if (r_wait == CW'(MEM_TIMEOUT - 1)) begin
          w_timeout_hit = 1'b1;
          w_state_next  = S_DONE;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge in_clr) begin
    if (in_clr) begin
      r_state   <= S_IDLE;
      r_wait    <= '0;
      r_timeout <= 1'b0;
      r_bus_err <= 1'b0;
    end else begin
      r_state <= w_state_next;
      // r_wait counts completed strobe cycles of the current transaction
      if (w_mem_active) r_wait <= r_wait + CW'(1);
      else              r_wait <= '0;
      if (w_timeout_hit) r_timeout <= 1'b1;
      if (w_multi)       r_bus_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge in_clr) begin
    if (in_clr) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (in_write_en[0]) begin
      r_regs[in_reg_addr] <= w_bus;
    end
  end

  always_ff @(posedge clk or posedge in_clr) begin
    if (in_clr) begin
      r_hi      <= '0;
      r_lo      <= '0;
      r_z       <= '0;
      r_pc      <= '0;
      r_mdr     <= '0;
      r_ir      <= '0;
      r_y       <= '0;
      r_mar     <= '0;
      r_outport <= '0;
      r_inport  <= '0;
    end else begin
      r_inport <= in_inport_data;
      if (in_write_en[1]) r_hi <= w_bus;
      if (in_write_en[2]) r_lo <= w_bus;
      if (in_write_en[3]) r_z  <= in_alu_result;
      if (in_inc_pc)           r_pc <= r_pc + WIDTH'(PC_STEP);
      else if (in_write_en[4]) r_pc <= w_bus;
      // MAR/MDR hold steady while a transaction is on the memory interface
      if (w_rd_capture)                         r_mdr <= in_mem_rdata;
      else if (in_write_en[5] && !w_mem_active) r_mdr <= w_bus;
      if (in_write_en[6]) r_ir <= w_bus;
      if (in_write_en[7]) r_y  <= w_bus;
      if (in_write_en[8] && !w_mem_active) r_mar <= w_bus;
      if (in_write_en[9]) r_outport <= w_bus;
    end
  end

  assign out_alu_a       = r_y;
  assign out_alu_b       = w_bus;
  assign out_mem_addr    = r_mar;
  assign out_mem_wdata   = r_mdr;
  assign out_mem_rd      = (r_state == S_RD);
  assign out_mem_wr      = (r_state == S_WR);
  assign out_mem_done    = (r_state == S_DONE);
  assign out_mem_timeout = r_timeout;
  assign out_busy        = (r_state != S_IDLE);
  assign out_bus         = w_bus;
  assign out_bus_err     = r_bus_err;
  assign out_ir          = r_ir;
  assign out_outport     = r_outport;

endmodule

// File: tb/tb_datapath_mem_seq.sv
// Bench for datapath_mem_seq: directed table, memory corner sequences and
// randomized cycles, all checked against a transaction-level model.
module tb_datapath_mem_seq;
  localparam int MEM_TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        clr;
  logic [8:0]  sel;
  logic [9:0]  we;
  logic [3:0]  addr;
  logic        baout, inc, mrd, mwr, ack;
  logic [31:0] rdata, inport;
  logic [63:0] alu;
  logic [31:0] alu_a, alu_b, mem_addr, mem_wdata, bus, ir, outport;
  logic        mem_rd, mem_wr, mem_done, mem_timeout, busy, bus_err;

  int n_vec = 0;
  int n_bad = 0;

  datapath_mem_seq dut (
    .clk(clk), .in_clr(clr), .in_bus_sel(sel), .in_write_en(we), .in_reg_addr(addr),
    .in_baout(baout), .in_inc_pc(inc), .in_mem_read(mrd), .in_mem_write(mwr),
    .in_mem_ack(ack), .in_mem_rdata(rdata), .in_inport_data(inport), .in_alu_result(alu),
    .out_alu_a(alu_a), .out_alu_b(alu_b), .out_mem_addr(mem_addr), .out_mem_wdata(mem_wdata),
    .out_mem_rd(mem_rd), .out_mem_wr(mem_wr), .out_mem_done(mem_done),
    .out_mem_timeout(mem_timeout), .out_busy(busy), .out_bus(bus), .out_bus_err(bus_err),
    .out_ir(ir), .out_outport(outport)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0]  sel;
    logic [9:0]  we;
    logic [3:0]  addr;
    logic        baout, inc, rd, wr, ack;
    logic [31:0] rdata, inport;
    logic [63:0] alu;
  } stim_t;

  typedef struct {
    stim_t       s;
    logic [31:0] exp_bus;
  } row_t;

  // Model state: architectural registers plus the memory transaction in flight
  logic [31:0] m_regs [16];
  logic [31:0] m_hi, m_lo, m_pc, m_mdr, m_ir, m_y, m_mar, m_out, m_in;
  logic [63:0] m_z;
  logic        m_err, m_tmo, m_done;
  int          m_kind;   // 0 none, 1 read, 2 write
  int          m_waited;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = '0;
    m_hi = 0; m_lo = 0; m_pc = 0; m_mdr = 0; m_ir = 0; m_y = 0; m_mar = 0;
    m_out = 0; m_in = 0; m_z = 0; m_err = 0; m_tmo = 0; m_done = 0;
    m_kind = 0; m_waited = 0;
  endtask

  function automatic logic [31:0] model_bus(input stim_t s);
    logic [31:0] src [9];
    int cext;
    cext = int'(m_ir & 32'h7FFFF);
    if (cext >= 262144) cext = cext - 524288;
    src[0] = (s.baout && s.addr == 0) ? 32'h0 : m_regs[s.addr];
    src[1] = m_hi;
    src[2] = m_lo;
    src[3] = m_z[63:32];
    src[4] = m_z[31:0];
    src[5] = m_pc;
    src[6] = m_mdr;
    src[7] = m_in;
    src[8] = 32'(cext);
    if ($countones(s.sel) != 1) return 32'h0;
    for (int i = 0; i < 9; i++) if (s.sel[i]) return src[i];
    return 32'h0;
  endfunction

  task automatic model_edge(input stim_t s);
    logic [31:0] b;
    logic        in_xfer;
    b       = model_bus(s);
    in_xfer = (m_kind != 0);
    if ($countones(s.sel) > 1) m_err = 1;
    if (s.we[0]) m_regs[s.addr] = b;
    if (s.we[1]) m_hi = b;
    if (s.we[2]) m_lo = b;
    if (s.we[3]) m_z = s.alu;
    if (s.inc) m_pc = m_pc + 32'd1;
    else if (s.we[4]) m_pc = b;
    if (s.we[5] && !in_xfer) m_mdr = b;
    if (s.we[6]) m_ir = b;
    if (s.we[7]) m_y = b;
    if (s.we[8] && !in_xfer) m_mar = b;
    if (s.we[9]) m_out = b;
    m_in = s.inport;
    if (m_done) begin
      m_done = 0;
    end else if (m_kind != 0) begin
      if (s.ack) begin
        if (m_kind == 1) m_mdr = s.rdata;
        m_kind = 0; m_done = 1;
      end else if (m_waited + 1 == MEM_TIMEOUT) begin
        m_tmo = 1; m_kind = 0; m_done = 1;
      end else begin
        m_waited++;
      end
    end else if (s.rd) begin
      m_kind = 1; m_waited = 0;
    end else if (s.wr) begin
      m_kind = 2; m_waited = 0;
    end
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic stim_t mk(input logic [8:0] s_sel, input logic [9:0] s_we,
                               input logic [3:0] s_addr, input logic s_baout,
                               input logic s_inc, input logic [31:0] s_in,
                               input logic [63:0] s_alu);
    stim_t s;
    s.sel = s_sel; s.we = s_we; s.addr = s_addr; s.baout = s_baout; s.inc = s_inc;
    s.rd = 0; s.wr = 0; s.ack = 0; s.rdata = 0; s.inport = s_in; s.alu = s_alu;
    return s;
  endfunction

  // Entered and left at posedge+1: drive, check the bus, clock, check registers
  task automatic apply(input stim_t s);
    sel = s.sel; we = s.we; addr = s.addr; baout = s.baout; inc = s.inc;
    mrd = s.rd; mwr = s.wr; ack = s.ack; rdata = s.rdata; inport = s.inport; alu = s.alu;
    #1;
    chk("bus", bus, model_bus(s));
    chk("alu_b", alu_b, model_bus(s));
    @(posedge clk);
    model_edge(s);
    #1;
    chk("bus_err", bus_err, m_err);
    chk("alu_a", alu_a, m_y);
    chk("mem_addr", mem_addr, m_mar);
    chk("mem_wdata", mem_wdata, m_mdr);
    chk("mem_rd", mem_rd, m_kind == 1);
    chk("mem_wr", mem_wr, m_kind == 2);
    chk("mem_done", mem_done, m_done);
    chk("mem_timeout", mem_timeout, m_tmo);
    chk("busy", busy, (m_kind != 0) || m_done);
    chk("ir", ir, m_ir);
    chk("outport", outport, m_out);
    if (mem_done) $display("mem txn done: addr=%h mdr=%h timeout=%b", mem_addr, mem_wdata, mem_timeout);
  endtask

  row_t  tbl [18];
  stim_t s;
  int    wr_cycles;
  logic  seen_done;

  initial begin
    clr = 1; sel = 0; we = 0; addr = 0; baout = 0; inc = 0; mrd = 0; mwr = 0;
    ack = 0; rdata = 0; inport = 0; alu = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_bus_err", bus_err, 0);
    chk("rst_timeout", mem_timeout, 0);
    clr = 0;

    tbl[0]  = '{mk(9'h000, 10'h000, 0, 0, 0, 32'h1234,     0), 32'h0};
    tbl[1]  = '{mk(9'h080, 10'h001, 3, 0, 0, 32'h00040000, 0), 32'h1234};
    tbl[2]  = '{mk(9'h001, 10'h000, 3, 0, 0, 32'h00040000, 0), 32'h1234};
    tbl[3]  = '{mk(9'h080, 10'h041, 0, 0, 0, 32'hFFFFFFFF, 0), 32'h00040000};
    tbl[4]  = '{mk(9'h100, 10'h000, 0, 0, 0, 32'hFFFFFFFF, 0), 32'hFFFC0000};
    tbl[5]  = '{mk(9'h001, 10'h000, 0, 1, 0, 32'hFFFFFFFF, 0), 32'h0};
    tbl[6]  = '{mk(9'h001, 10'h000, 0, 0, 0, 32'hFFFFFFFF, 0), 32'h00040000};
    tbl[7]  = '{mk(9'h080, 10'h010, 0, 0, 0, 32'h5,        0), 32'hFFFFFFFF};
    tbl[8]  = '{mk(9'h020, 10'h000, 0, 0, 0, 32'h5,        0), 32'hFFFFFFFF};
    tbl[9]  = '{mk(9'h080, 10'h018, 0, 0, 1, 32'h5, 64'h1_00000002), 32'h5};
    tbl[10] = '{mk(9'h020, 10'h000, 0, 0, 0, 32'h0,        0), 32'h0};
    tbl[11] = '{mk(9'h008, 10'h000, 0, 0, 0, 32'h0,        0), 32'h1};
    tbl[12] = '{mk(9'h010, 10'h286, 0, 0, 0, 32'h0,        0), 32'h2};
    tbl[13] = '{mk(9'h002, 10'h000, 0, 0, 0, 32'h0,        0), 32'h2};
    tbl[14] = '{mk(9'h004, 10'h000, 0, 0, 0, 32'h0,        0), 32'h2};
    tbl[15] = '{mk(9'h003, 10'h000, 0, 0, 0, 32'h0,        0), 32'h0};
    tbl[16] = '{mk(9'h000, 10'h000, 0, 0, 0, 32'h77,       0), 32'h0};
    tbl[17] = '{mk(9'h080, 10'h010, 0, 0, 0, 32'h0,        0), 32'h77};
    for (int i = 0; i < 18; i++) begin
      sel = tbl[i].s.sel; addr = tbl[i].s.addr; baout = tbl[i].s.baout;
      #1;
      chk("tbl_bus", bus, tbl[i].exp_bus);
      #1;
      apply(tbl[i].s);
      $display("row %0d sel=%h we=%h bus_exp=%h err=%b", i, tbl[i].s.sel, tbl[i].s.we, tbl[i].exp_bus, bus_err);
    end
    chk("err_sticky", bus_err, 1);

    // Reset in the middle of a read
    s = mk(0, 0, 0, 0, 0, 0, 0); s.rd = 1; apply(s);
    apply(mk(0, 0, 0, 0, 0, 0, 0));
    chk("rd_strobe_pre_clr", mem_rd, 1);
    clr = 1; sel = 9'h020;
    #1;
    chk("clr_mem_rd", mem_rd, 0);
    chk("clr_busy", busy, 0);
    chk("clr_bus_err", bus_err, 0);
    chk("clr_pc", bus, 0);
    model_reset();
    @(posedge clk); #1;
    clr = 0;
    $display("reset mid-read done");

    // Acked read, ack on the fourth strobe cycle, MAR write attempted while waiting
    apply(mk(9'h000, 10'h000, 0, 0, 0, 32'h40, 0));
    apply(mk(9'h080, 10'h100, 0, 0, 0, 32'h0, 0));
    s = mk(0, 0, 0, 0, 0, 0, 0); s.rd = 1; apply(s);
    apply(mk(9'h000, 10'h000, 0, 0, 0, 32'h99, 0));
    apply(mk(9'h080, 10'h120, 0, 0, 0, 32'h0, 0));
    apply(mk(0, 0, 0, 0, 0, 0, 0));
    s = mk(0, 0, 0, 0, 0, 0, 0); s.ack = 1; s.rdata = 32'hDEADBEEF; apply(s);
    chk("rd_done", mem_done, 1);
    chk("rd_mdr", mem_wdata, 32'hDEADBEEF);
    chk("rd_mar_held", mem_addr, 32'h40);
    apply(mk(0, 0, 0, 0, 0, 0, 0));
    chk("rd_done_one_cycle", mem_done, 0);

    // Write with no ack runs into the timeout
    apply(mk(9'h000, 10'h000, 0, 0, 0, 32'hA5, 0));
    apply(mk(9'h080, 10'h020, 0, 0, 0, 32'h0, 0));
    s = mk(0, 0, 0, 0, 0, 0, 0); s.wr = 1; apply(s);
    wr_cycles = 0; seen_done = 0;
    for (int i = 0; i < 25 && !seen_done; i++) begin
      if (mem_wr) wr_cycles++;
      if (mem_done) seen_done = 1;
      else apply(mk(0, 0, 0, 0, 0, 0, 0));
    end
    chk("wr_strobe_cycles", wr_cycles, MEM_TIMEOUT);
    chk("wr_done_seen", seen_done, 1);
    chk("wr_timeout", mem_timeout, 1);
    chk("wr_mdr_kept", mem_wdata, 32'hA5);
    apply(mk(0, 0, 0, 0, 0, 0, 0));
    s = mk(0, 0, 0, 0, 0, 0, 0); s.rd = 1; apply(s);
    s = mk(0, 0, 0, 0, 0, 0, 0); s.ack = 1; s.rdata = 32'h13579BDF; apply(s);
    chk("rd2_done", mem_done, 1);
    chk("rd2_mdr", mem_wdata, 32'h13579BDF);

    // Randomized cycles
    for (int i = 0; i < 400; i++) begin
      s.addr  = 4'($urandom_range(0, 15));
      s.baout = 1'($urandom_range(0, 3) == 0);
      s.inc   = 1'($urandom_range(0, 7) == 0);
      s.rd    = 1'($urandom_range(0, 9) == 0);
      s.wr    = 1'($urandom_range(0, 9) == 0);
      s.ack   = 1'($urandom_range(0, 3) == 0);
      s.rdata = $urandom;
      s.inport = $urandom;
      s.alu   = {$urandom, $urandom};
      s.we    = 10'($urandom) & 10'($urandom);
      if ($urandom_range(0, 63) == 0) s.sel = 9'($urandom);
      else if ($urandom_range(0, 7) == 0) s.sel = 9'h000;
      else s.sel = 9'(1 << $urandom_range(0, 8));
      apply(s);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
